// File: rtl/mux_arb_if.sv
// Request/grant/select bundle between four requesters and the mux round-robin arbiter.
// MUX_ARB_LOCK_EN adds the lock input that freezes the grant hold timer.
interface mux_arb_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       tmo;
`ifdef MUX_ARB_LOCK_EN
    logic       lock;

    modport master (output req, output lock, input gnt, input s1, input s0, input busy, input tmo);
    modport slave  (input req, input lock, output gnt, output s1, output s0, output busy, output tmo);
`else
    modport master (output req, input gnt, input s1, input s0, input busy, input tmo);
    modport slave  (input req, output gnt, output s1, output s0, output busy, output tmo);
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select pins of a 4:1 mux, with a bounded grant hold timer.
// Optional MUX_ARB_LOCK_EN: lock input freezes the hold timer while a grant is active.
module mux_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CW       = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_arb_if.slave  bus
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IW   = 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            tmo_q, tmo_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            freeze;

`ifdef MUX_ARB_LOCK_EN
    assign freeze = bus.lock;
`else
    assign freeze = 1'b0;
`endif

    // State register; sel_q doubles as the granted index since it only moves on IDLE->GRANT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    // First requester at or after ptr, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ptr_q + IW'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next state and outputs; timeout wins over a simultaneous req drop.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (found) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    gnt_d   = NREQ'(1) << pick;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if ((!freeze && cnt_q == CNT_LAST) || !bus.req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + IW'(1);
                    tmo_d   = !freeze && (cnt_q == CNT_LAST);
                end else if (!freeze) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.gnt  = gnt_q;
    assign bus.s1   = sel_q[1];
    assign bus.s0   = sel_q[0];
    assign bus.busy = busy_q;
    assign bus.tmo  = tmo_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: vector table on a HOLD_MAX=3 instance plus hand sequences
// for mid-grant reset (HOLD_MAX=8) and, with MUX_ARB_LOCK_EN, the lock freeze (HOLD_MAX=2).
module tb_mux_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    mux_arb_if a_if();
    mux_arb_if b_if();

    mux_rr_arbiter #(.HOLD_MAX(3), .CW(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    mux_rr_arbiter #(.HOLD_MAX(8), .CW(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

`ifdef MUX_ARB_LOCK_EN
    mux_arb_if c_if();
    mux_rr_arbiter #(.HOLD_MAX(2), .CW(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [3:0] req, logic [3:0] gnt, logic [1:0] sel,
                                logic busy, logic tmo, int reps);
        vec_t v;
        v.req = req; v.gnt = gnt; v.sel = sel; v.busy = busy; v.tmo = tmo;
        for (int r = 0; r < reps; r++) vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_b(string nm, logic [3:0] gnt, logic [1:0] sel, logic busy, logic tmo);
        chk({nm, ".gnt"}, 8'(b_if.gnt), 8'(gnt));
        chk({nm, ".sel"}, 8'({b_if.s1, b_if.s0}), 8'(sel));
        chk({nm, ".busy_tmo"}, 8'({b_if.busy, b_if.tmo}), 8'({busy, tmo}));
    endtask

    logic [3:0] ival;
    logic       d_act;
    logic       d_exp;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        ival     = 4'b0101;
        rst_n    = 1'b0;
        a_if.req = 4'b1111;
        b_if.req = 4'b0000;
`ifdef MUX_ARB_LOCK_EN
        a_if.lock = 1'b0;
        b_if.lock = 1'b0;
        c_if.req  = 4'b0000;
        c_if.lock = 1'b0;
`endif

        // Round robin with HOLD_MAX=3, normal release, ptr-based reprioritisation.
        add(4'hF, 4'b0001, 2'd0, 1'b1, 1'b0, 3);
        add(4'hF, 4'b0000, 2'd0, 1'b0, 1'b1, 1);
        add(4'hF, 4'b0010, 2'd1, 1'b1, 1'b0, 3);
        add(4'hF, 4'b0000, 2'd1, 1'b0, 1'b1, 1);
        add(4'hF, 4'b0100, 2'd2, 1'b1, 1'b0, 3);
        add(4'hF, 4'b0000, 2'd2, 1'b0, 1'b1, 1);
        add(4'hF, 4'b1000, 2'd3, 1'b1, 1'b0, 3);
        add(4'hF, 4'b0000, 2'd3, 1'b0, 1'b1, 1);
        add(4'hF, 4'b0001, 2'd0, 1'b1, 1'b0, 1);
        add(4'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1);
        add(4'h4, 4'b0100, 2'd2, 1'b1, 1'b0, 2);
        add(4'h0, 4'b0000, 2'd2, 1'b0, 1'b0, 1);
        add(4'h5, 4'b0001, 2'd0, 1'b1, 1'b0, 1);
        add(4'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1);

        // Reset held two edges with all requests up.
        tick();
        tick();
        chk("rst.gnt", 8'(a_if.gnt), 8'h00);
        chk("rst.sel", 8'({a_if.s1, a_if.s0}), 8'h00);
        chk("rst.busy", 8'(a_if.busy), 8'h00);
        chk("rst.tmo", 8'(a_if.tmo), 8'h00);
        chk("rst.b_gnt", 8'(b_if.gnt), 8'h00);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            a_if.req = vecs[i].req;
            tick();
            chk($sformatf("vec%0d.gnt", i), 8'(a_if.gnt), 8'(vecs[i].gnt));
            chk($sformatf("vec%0d.sel", i), 8'({a_if.s1, a_if.s0}), 8'(vecs[i].sel));
            chk($sformatf("vec%0d.busy_tmo", i), 8'({a_if.busy, a_if.tmo}),
                8'({vecs[i].busy, vecs[i].tmo}));
            d_act = ival[{a_if.s1, a_if.s0}];
            d_exp = ival[vecs[i].sel];
            chk($sformatf("vec%0d.d", i), 8'(d_act), 8'(d_exp));
        end

        // Mid-grant reset: requester 3 granted with cnt=5, then reset for one edge.
        a_if.req = 4'b0000;
        b_if.req = 4'b1000;
        tick();
        chk_b("mid.grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        chk_b("mid.cnt5", 4'b1000, 2'd3, 1'b1, 1'b0);
        rst_n    = 1'b0;
        b_if.req = 4'b1001;
        tick();
        chk_b("mid.rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_b("mid.regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
        // Full HOLD_MAX=8 tenure, then timeout and rotation to the other requester.
        for (int k = 0; k < 7; k++) tick();
        chk_b("hold8.last", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        chk_b("hold8.tmo", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_b("hold8.next", 4'b1000, 2'd3, 1'b1, 1'b0);
        b_if.req = 4'b0000;
        tick();
        chk_b("hold8.rel", 4'b0000, 2'd3, 1'b0, 1'b0);

`ifdef MUX_ARB_LOCK_EN
        // Lock freezes the hold timer; timeout resumes once lock drops.
        c_if.req  = 4'b0010;
        c_if.lock = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("lock%0d.gnt", k), 8'(c_if.gnt), 8'h02);
            chk($sformatf("lock%0d.tmo", k), 8'(c_if.tmo), 8'h00);
        end
        c_if.lock = 1'b0;
        tick();
        chk("unlock1.gnt", 8'(c_if.gnt), 8'h02);
        chk("unlock1.tmo", 8'(c_if.tmo), 8'h00);
        tick();
        chk("unlock2.gnt", 8'(c_if.gnt), 8'h00);
        chk("unlock2.tmo", 8'(c_if.tmo), 8'h01);
        c_if.req = 4'b0000;
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4:1 single-wire mux (select lines s1/s0, data inputs i0..i3, output d) between four requesters.
- Requester k owns mux input ik; the arbiter drives s1/s0 so that d carries the granted requester's bit.
- Grant tenure is bounded by a hold timer, so no requester can monopolise the wire.
- Sits directly in front of the mux select pins; one arbiter per mux instance.

Parameters:
- HOLD_MAX, 15: maximum number of cycles a single grant may last. Legal range 1..255.
- CW, 8: width of the internal hold counter. Must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  4  level request; req[k] asks for mux input ik.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- s1  output  1  mux select MSB, registered.
- s0  output  1  mux select LSB, registered.
- busy  output  1  high while any grant is active.
- tmo  output  1  one-cycle pulse when a grant is ended by the hold timer.

Behaviour:
- Reset (rst_n=0 at a clock edge), regardless of state, with no partial grant surviving:
  - gnt=4'b0000, s1=0, s0=0, busy=0, tmo=0.
  - state=IDLE, ptr=0, cnt=0.
- ptr (2 bits) is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- State IDLE:
  - If req is nonzero, pick the first set bit in search order as idx.
  - Next edge: gnt=1<<idx, {s1,s0}=idx, busy=1, cnt=0, state=GRANT.
  - Latency from req sampled high in IDLE to gnt high is 1 cycle.
  - If req==0: remain in IDLE. gnt=0, busy=0. s1/s0 hold their last value so d does not glitch.
- State GRANT:
  - cnt increments every cycle.
  - Release when req[idx]==0 at an edge (normal release), or when cnt==HOLD_MAX-1 (timeout; tmo=1 for exactly that next cycle).
  - On release, next edge: gnt=0, busy=0, ptr=idx+1 mod 4, state=IDLE. s1/s0 unchanged.
  - Consequently gnt is high for at most HOLD_MAX consecutive cycles.
  - There is always at least one idle cycle between grants (break-before-make on gnt).
- Simultaneous events:
  - Normal release and timeout on the same edge count as a timeout (tmo=1).
  - Requests from non-granted requesters during GRANT are ignored until IDLE; they are not latched.
  - A requester that timed out and keeps req high competes again with the lowest priority, because ptr has moved past it.
- s1/s0 change only on the IDLE->GRANT edge.
- gnt is always one-hot or zero. gnt, {s1,s0} and busy are mutually consistent whenever busy=1.
- ptr wraps from 3 to 0.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- When defined:
  - Extra input port lock (1 bit).
  - While in GRANT and lock=1, the hold timer is frozen (cnt does not increment) and timeout cannot occur. Normal release via req drop still works.
  - lock is ignored in IDLE.
- When undefined: no lock port; behaviour exactly as above.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with req=4'b1111 -> gnt=0, s1=0, s0=0, busy=0, tmo=0. On release of rst_n, gnt=4'b0001 one cycle later.
- Round-robin: req=4'b1111 held, HOLD_MAX=3 -> gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001. {s1,s0} takes 00, 01, 10, 11 respectively. Each grant lasts 3 cycles and tmo pulses each time.
- Normal release: req=4'b0100 for 2 cycles, then 0 -> gnt=0100 and {s1,s0}=10 for 2 cycles, then gnt=0, tmo=0, ptr=3. A subsequent req=4'b0101 grants 0001 (search order 3,0,1,2).
- Data path with mux attached: i0=1, i1=0, i2=1, i3=0; request each k in turn -> d equals ik during every grant cycle, and d does not change during idle gaps.
- Reset mid-grant: gnt=1000 with cnt=5, assert rst_n=0 for 1 edge -> next cycle gnt=0, s1=s0=0, ptr=0. With req=4'b1001 after reset, the grant goes to index 0.
- MUX_ARB_LOCK_EN defined, HOLD_MAX=2: req[1]=1 and lock=1 for 10 cycles -> gnt=0010 for 10 cycles, tmo never pulses. Drop lock with req held -> release exactly 2 cycles later with tmo=1.
